// File: rtl/cache_cmd_exec_pkg.sv
// Shared command codes and FSM encodings for the cache maintenance engine.
// The cache_io_cmd_* codes are the same values the cache front end issues.
package cache_cmd_exec_pkg;

   localparam logic [2:0] cache_io_cmd_clear = 3'd1;
   localparam logic [2:0] cache_io_cmd_wb    = 3'd2;

   localparam logic [2:0] enc_idle = 3'd0;
   localparam logic [2:0] enc_rd   = 3'd1;
   localparam logic [2:0] enc_cap  = 3'd2;
   localparam logic [2:0] enc_way  = 3'd3;
   localparam logic [2:0] enc_wb   = 3'd4;
   localparam logic [2:0] enc_upd  = 3'd5;
   localparam logic [2:0] enc_done = 3'd6;

   typedef enum logic [2:0] {
      s_idle = enc_idle,
      s_rd   = enc_rd,
      s_cap  = enc_cap,
      s_way  = enc_way,
      s_wb   = enc_wb,
      s_upd  = enc_upd,
      s_done = enc_done
   } state_t;

endpackage

// File: rtl/cache_cmd_exec.sv
// Cache maintenance engine: walks every set/way of the status RAM and performs
// write-back (wb) or write-back-and-invalidate (clear) on each line.
module cache_cmd_exec
   import cache_cmd_exec_pkg::*;
#(
   parameter int SET_NUM    = 64,
   parameter int WAY_NUM    = 4,
   parameter int LINE_BYTES = 16,
   localparam int IDX_W = $clog2(SET_NUM),
   localparam int OFF_W = $clog2(LINE_BYTES),
   localparam int TAG_W = 32 - IDX_W - OFF_W,
   localparam int WAY_W = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1
) (
   input  logic                         clk,
   input  logic                         rest,
   input  logic [2:0]                   cmd,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   output logic                         busy,
   output logic [IDX_W-1:0]             st_addr,
   output logic                         st_rd,
   input  logic [WAY_NUM*(TAG_W+2)-1:0] st_rdData,
   output logic                         st_wr,
   output logic [WAY_W-1:0]             st_wrWay,
   output logic                         st_wrValid,
   output logic                         st_wrDirty,
   output logic                         wb_req,
   output logic [31:0]                  wb_addr,
   output logic [WAY_W-1:0]             wb_way,
   input  logic                         wb_ack,
   output logic [15:0]                  wb_count
);

   localparam int ENT_W = TAG_W + 2;

   state_t                     state;
   logic [2:0]                 cmd_q;
   logic [IDX_W-1:0]           set_cnt;
   logic [WAY_W-1:0]           way_cnt;
   logic [WAY_NUM*ENT_W-1:0]   line_st;

   logic [ENT_W-1:0]           ent;
   logic                       ent_valid;
   logic                       ent_dirty;
   logic [TAG_W-1:0]           ent_tag;
   logic                       last_way;
   logic                       last_set;
   logic                       is_wb;

   state_t                     adv_state;
   logic [WAY_W-1:0]           adv_way;
   logic [IDX_W-1:0]           adv_set;
   logic                       adv_rd;

   assign ent       = line_st[way_cnt*ENT_W +: ENT_W];
   assign ent_valid = ent[ENT_W-1];
   assign ent_dirty = ent[ENT_W-2];
   assign ent_tag   = ent[TAG_W-1:0];
   assign last_way  = (way_cnt == WAY_W'(WAY_NUM - 1));
   assign last_set  = (set_cnt == IDX_W'(SET_NUM - 1));
   assign is_wb     = (cmd_q == cache_io_cmd_wb);

   // Next position after finishing way w: next way, next set, or done.
   always_comb begin
      adv_state = s_done;
      adv_way   = way_cnt;
      adv_set   = set_cnt;
      adv_rd    = 1'b0;
      if (!last_way) begin
         adv_state = s_way;
         adv_way   = way_cnt + 1'b1;
      end else if (!last_set) begin
         adv_state = s_rd;
         adv_way   = '0;
         adv_set   = set_cnt + 1'b1;
         adv_rd    = 1'b1;
      end
   end

   // Handshake: cmd_valid is held until cmd_ready; cmd_ready is a one-cycle
   // pulse registered out of DONE, and no new command is taken in that cycle
   // so a requester still holding cmd_valid is not accepted twice.
   always_ff @(posedge clk or posedge rest) begin
      if (rest) begin
         state      <= s_idle;
         cmd_q      <= '0;
         set_cnt    <= '0;
         way_cnt    <= '0;
         line_st    <= '0;
         cmd_ready  <= 1'b0;
         busy       <= 1'b0;
         st_addr    <= '0;
         st_rd      <= 1'b0;
         st_wr      <= 1'b0;
         st_wrWay   <= '0;
         st_wrValid <= 1'b0;
         st_wrDirty <= 1'b0;
         wb_req     <= 1'b0;
         wb_addr    <= '0;
         wb_way     <= '0;
         wb_count   <= '0;
      end else begin
         st_rd     <= 1'b0;
         st_wr     <= 1'b0;
         cmd_ready <= 1'b0;
         case (state)
            s_idle: begin
               if (cmd_valid && !cmd_ready) begin
                  cmd_q    <= cmd;
                  set_cnt  <= '0;
                  way_cnt  <= '0;
                  wb_count <= '0;
                  busy     <= 1'b1;
                  if (cmd == cache_io_cmd_clear || cmd == cache_io_cmd_wb) begin
                     state   <= s_rd;
                     st_rd   <= 1'b1;
                     st_addr <= '0;
                  end else begin
                     state <= s_done;
                  end
               end
            end
            s_rd: begin
               state <= s_cap;
            end
            s_cap: begin
               line_st <= st_rdData;
               state   <= s_way;
            end
            s_way: begin
               if (ent_valid && ent_dirty) begin
                  state   <= s_wb;
                  wb_req  <= 1'b1;
                  wb_addr <= {ent_tag, set_cnt, {OFF_W{1'b0}}};
                  wb_way  <= way_cnt;
               end else if (cmd_q == cache_io_cmd_clear && ent_valid) begin
                  state      <= s_upd;
                  st_wr      <= 1'b1;
                  st_wrWay   <= way_cnt;
                  st_wrValid <= 1'b0;
                  st_wrDirty <= 1'b0;
               end else begin
                  state   <= adv_state;
                  way_cnt <= adv_way;
                  set_cnt <= adv_set;
                  st_rd   <= adv_rd;
                  st_addr <= adv_set;
               end
            end
            s_wb: begin
               if (wb_ack) begin
                  wb_req <= 1'b0;
                  if (wb_count != 16'hFFFF) wb_count <= wb_count + 16'd1;
                  state      <= s_upd;
                  st_wr      <= 1'b1;
                  st_wrWay   <= way_cnt;
                  st_wrValid <= is_wb;
                  st_wrDirty <= 1'b0;
               end
            end
            s_upd: begin
               state   <= adv_state;
               way_cnt <= adv_way;
               set_cnt <= adv_set;
               st_rd   <= adv_rd;
               st_addr <= adv_set;
            end
            s_done: begin
               state     <= s_idle;
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
            end
            default: begin
               state <= s_idle;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cache_cmd_exec.sv
// Bench for cache_cmd_exec: status-RAM and write-back responder models,
// directed commands, and a queue-based scoreboard checked by a monitor.
module tb_cache_cmd_exec;
   import cache_cmd_exec_pkg::*;

   localparam int SETS  = 64;
   localparam int WAYS  = 4;
   localparam int IDX_W = 6;
   localparam int TAG_W = 22;
   localparam int WAY_W = 2;
   localparam int ENT_W = TAG_W + 2;
   localparam int CLEAN_LAT = SETS * (2 + WAYS) + 1 + 1;

   logic                  clk = 1'b0;
   logic                  rest = 1'b1;
   logic [2:0]            cmd = 3'd0;
   logic                  cmd_valid = 1'b0;
   logic                  cmd_ready;
   logic                  busy;
   logic [IDX_W-1:0]      st_addr;
   logic                  st_rd;
   logic [WAYS*ENT_W-1:0] st_rdData = '0;
   logic                  st_wr;
   logic [WAY_W-1:0]      st_wrWay;
   logic                  st_wrValid;
   logic                  st_wrDirty;
   logic                  wb_req;
   logic [31:0]           wb_addr;
   logic [WAY_W-1:0]      wb_way;
   logic                  wb_ack = 1'b0;
   logic [15:0]           wb_count;

   cache_cmd_exec #(.SET_NUM(SETS), .WAY_NUM(WAYS), .LINE_BYTES(16)) dut (
      .clk(clk), .rest(rest), .cmd(cmd), .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready), .busy(busy), .st_addr(st_addr), .st_rd(st_rd),
      .st_rdData(st_rdData), .st_wr(st_wr), .st_wrWay(st_wrWay),
      .st_wrValid(st_wrValid), .st_wrDirty(st_wrDirty), .wb_req(wb_req),
      .wb_addr(wb_addr), .wb_way(wb_way), .wb_ack(wb_ack), .wb_count(wb_count)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_err = 0;
   logic [WAY_W+31:0]        exp_wb_q[$];
   logic [IDX_W+WAY_W+1:0]   exp_st_q[$];
   logic [31:0]              exp_done_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: got an output event, expected none", name);
   endtask

   // ---------------- environment models ----------------
   logic [ENT_W-1:0] mem      [SETS][WAYS];
   logic [ENT_W-1:0] init_mem [SETS][WAYS];
   logic             load = 1'b0;

   always @(posedge clk) begin
      if (load) mem <= init_mem;
      else if (st_wr)
         mem[st_addr][st_wrWay] <= {st_wrValid, st_wrDirty, mem[st_addr][st_wrWay][TAG_W-1:0]};
      if (st_rd)
         for (int w = 0; w < WAYS; w++) st_rdData[w*ENT_W +: ENT_W] <= mem[st_addr][w];
   end

   int ack_delay   = 7;
   int wb_wait     = 0;
   int inject_seq  = 0;
   int inject_done = 0;

   always begin
      @(negedge clk);
      if (inject_done < inject_seq && st_rd && !rest) begin
         inject_done++;
         wb_ack = 1'b1;
         @(negedge clk);
         wb_ack = 1'b0;
      end else if (wb_req) begin
         wb_wait++;
         if (wb_wait >= ack_delay) begin
            wb_ack = 1'b1;
            @(negedge clk);
            wb_ack  = 1'b0;
            wb_wait = 0;
         end
      end else begin
         wb_wait = 0;
      end
   end

   // ---------------- monitor ----------------
   int                start_cyc = 0;
   int                rd_total = 0;
   int                rd_since_rst = 0;
   int                overlap = 0;
   logic [IDX_W-1:0]  first_rd_addr = '0;
   logic              wb_req_prev = 1'b0;
   logic [31:0]       held_addr = '0;
   logic [WAY_W+31:0] m_wb;
   logic [IDX_W+WAY_W+1:0] m_st;
   logic [31:0]       m_done;

   always @(negedge clk) begin
      if (rest) begin
         rd_since_rst = 0;
      end else begin
         if (st_rd) begin
            if (rd_since_rst == 0) first_rd_addr = st_addr;
            rd_since_rst++;
            rd_total++;
         end
         if (st_wr && wb_req) overlap++;
         if (wb_req && !wb_req_prev) begin
            if (exp_wb_q.size() == 0) unexpected("wb_req");
            else begin
               m_wb = exp_wb_q.pop_front();
               check("wb_addr", 64'(wb_addr), 64'(m_wb[31:0]));
               check("wb_way", 64'(wb_way), 64'(m_wb[WAY_W+31:32]));
               held_addr = wb_addr;
            end
         end else if (wb_req) begin
            check("wb_addr_stable", 64'(wb_addr), 64'(held_addr));
         end
         if (st_wr) begin
            if (exp_st_q.size() == 0) unexpected("st_wr");
            else begin
               m_st = exp_st_q.pop_front();
               check("st_wr_set_way_v_d", 64'({st_addr, st_wrWay, st_wrValid, st_wrDirty}), 64'(m_st));
            end
         end
         if (cmd_ready) begin
            if (exp_done_q.size() == 0) unexpected("cmd_ready");
            else begin
               m_done = exp_done_q.pop_front();
               check("done_wb_count", 64'(wb_count), 64'(m_done[31:16]));
               check("done_latency", 64'(cyc - start_cyc), 64'(m_done[15:0]));
            end
         end
      end
      wb_req_prev = wb_req;
   end

   // ---------------- driver tasks ----------------
   logic [15:0] last_wbc = '0;

   task automatic load_mem();
      @(negedge clk);
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic clear_init();
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++) init_mem[s][w] = '0;
   endtask

   task automatic start_cmd(input logic [2:0] c);
      logic [ENT_W-1:0] e;
      int n_wb;
      int lat;
      n_wb = 0;
      lat  = 2;
      if (c == cache_io_cmd_clear || c == cache_io_cmd_wb) begin
         lat = CLEAN_LAT;
         for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
               e = init_mem[s][w];
               if (e[ENT_W-1] && e[ENT_W-2]) begin
                  exp_wb_q.push_back({WAY_W'(w), e[TAG_W-1:0], IDX_W'(s), 4'b0000});
                  exp_st_q.push_back({IDX_W'(s), WAY_W'(w), (c == cache_io_cmd_wb), 1'b0});
                  n_wb++;
                  lat += ack_delay + 1;
               end else if (c == cache_io_cmd_clear && e[ENT_W-1]) begin
                  exp_st_q.push_back({IDX_W'(s), WAY_W'(w), 1'b0, 1'b0});
                  lat += 1;
               end
            end
      end
      last_wbc = 16'(n_wb);
      exp_done_q.push_back({16'(n_wb), 16'(lat)});
      @(negedge clk);
      cmd       = c;
      cmd_valid = 1'b1;
      start_cyc = cyc;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      @(negedge clk);
      cmd = 3'b111;
      while (!cmd_ready && n < 20000) begin
         @(negedge clk);
         n++;
      end
      check("cmd_ready_seen", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("wb_count_hold", 64'(wb_count), 64'(last_wbc));
      check("busy_after_done", 64'(busy), 64'd0);
      check("queues_drained", 64'(exp_wb_q.size() + exp_st_q.size() + exp_done_q.size()), 64'd0);
   endtask

   // ---------------- directed tests ----------------
   int rd0;
   int n;

   initial begin
      clear_init();
      load_mem();
      repeat (2) @(negedge clk);
      check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_st_rd", 64'(st_rd), 64'd0);
      check("rst_st_wr", 64'(st_wr), 64'd0);
      check("rst_wb_req", 64'(wb_req), 64'd0);
      check("rst_st_addr", 64'(st_addr), 64'd0);
      check("rst_wb_addr", 64'(wb_addr), 64'd0);
      check("rst_wb_count", 64'(wb_count), 64'd0);
      rest = 1'b0;
      repeat (2) @(negedge clk);

      // clean cache, wb: no traffic, ready 385 cycles after the accepting edge
      rd0 = rd_total;
      start_cmd(cache_io_cmd_wb);
      wait_done();
      check("clean_st_rd_count", 64'(rd_total - rd0), 64'(SETS));

      // one dirty line: set 5 way 2, tag 0x12345, ack after 7 cycles
      init_mem[5][2] = {1'b1, 1'b1, 22'h12345};
      load_mem();
      ack_delay = 7;
      start_cmd(cache_io_cmd_wb);
      wait_done();
      check("dirty_line_cleaned", 64'(mem[5][2]), 64'({1'b1, 1'b0, 22'h12345}));

      // clear: all lines valid, 10 dirty
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++)
            init_mem[s][w] = {1'b1, (s % 7 == 0) && (w == s % 4), TAG_W'(32'h1000 + s * 4 + w)};
      load_mem();
      ack_delay = 3;
      start_cmd(cache_io_cmd_clear);
      wait_done();
      check("clear_wb_count", 64'(wb_count), 64'd10);
      check("clear_line_invalid", 64'(mem[63][3][ENT_W-1]), 64'd0);

      // unrecognised command: straight to DONE, no status traffic
      rd0 = rd_total;
      start_cmd(3'b111);
      wait_done();
      check("bad_cmd_no_st_rd", 64'(rd_total - rd0), 64'd0);

      // stray wb_ack during RD on a clean cache
      clear_init();
      load_mem();
      start_cmd(cache_io_cmd_wb);
      inject_seq++;
      wait_done();
      check("stray_ack_used", 64'(inject_done), 64'(inject_seq));

      // reset while wb_req is outstanding, then restart
      init_mem[5][2] = {1'b1, 1'b1, 22'h12345};
      load_mem();
      ack_delay = 1000;
      start_cmd(cache_io_cmd_wb);
      n = 0;
      while (!wb_req && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("wb_req_before_reset", 64'(wb_req), 64'd1);
      #2;
      rest = 1'b1;
      #1;
      check("reset_wb_req", 64'(wb_req), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_wb_count", 64'(wb_count), 64'd0);
      cmd_valid = 1'b0;
      exp_wb_q.delete();
      exp_st_q.delete();
      exp_done_q.delete();
      @(negedge clk);
      rest = 1'b0;
      ack_delay = 7;
      load_mem();
      start_cmd(cache_io_cmd_wb);
      wait_done();
      check("restart_first_set", 64'(first_rd_addr), 64'd0);

      check("st_wr_wb_req_overlap", 64'(overlap), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
